// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage and its neighbours.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    fetch_nope = 2'd0,
    fetch_keep = 2'd1,
    fetch_next = 2'd2
  } fetch_state_e;

  typedef struct packed {
    fetch_state_e state;
  } fetch_req_t;

  typedef struct packed {
    logic            take_branch;
    logic [XLEN-1:0] branch_value;
  } wb_to_fetch_req_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] raw_instruction;
  } fetch_to_decoder_info_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: one request channel, one response channel.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            req_valid_c;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  modport master (
    output req_valid_c, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid_c, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps a single imem read in flight,
// and presents the fetched word to decode with hold/replay/redirect control.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  fetch_req_t             fetch_req_i,
  input  wb_to_fetch_req_t       wb_to_fetch_req_i,
  fetch_stage_if.master          imem,
  output fetch_to_decoder_info_t fetch_to_decoder_o,
  output logic [XLEN-1:0]        pc_o
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic                   kill_q, kill_d;
  fetch_to_decoder_info_t out_q, out_d;
  logic [XLEN-1:0]        pc_out_q, pc_out_d;

  logic                   req_valid;
  logic                   handshake;
  logic                   redirect;
  logic [XLEN-1:0]        target;

  assign req_valid = (state_q == ST_REQ) && (fetch_req_i.state != fetch_nope);
  assign handshake = req_valid && imem.req_ready;
  assign redirect  = wb_to_fetch_req_i.take_branch;
  assign target    = wb_to_fetch_req_i.branch_value & ~XLEN'(3);

  // Request is suppressed while reset is held even though the FSM sits in REQ.
  assign imem.req_valid_c = req_valid && rst_ni;
  assign imem.req_addr    = pc_q;

  // Next-state logic; a redirect overrides the downstream request everywhere.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    out_d    = out_q;
    pc_out_d = pc_out_q;

    if (redirect) begin
      pc_d = target;
    end

    unique case (state_q)
      ST_REQ: begin
        if (handshake) begin
          state_d = ST_WAIT;
          kill_d  = redirect;
        end
      end

      ST_WAIT: begin
        if (imem.rsp_valid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            out_d.valid           = 1'b1;
            out_d.raw_instruction = imem.rsp_data;
            pc_out_d              = pc_q;
            state_d               = ST_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          out_d.valid = 1'b0;
          state_d     = ST_REQ;
        end else begin
          unique case (fetch_req_i.state)
            fetch_next: begin
              pc_d        = pc_q + XLEN'(4);
              out_d.valid = 1'b0;
              state_d     = ST_REQ;
            end
            fetch_nope: begin
              out_d.valid = 1'b0;
              state_d     = ST_REQ;
            end
            default: ;
          endcase
        end
      end

      default: begin
        state_d = ST_REQ;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      kill_q   <= 1'b0;
      out_q    <= '0;
      pc_out_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      out_q    <= out_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign fetch_to_decoder_o = out_q;
  assign pc_o               = pc_out_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a transaction-level model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h100;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  fetch_req_t             fetch_req;
  wb_to_fetch_req_t       wb_req;
  fetch_to_decoder_info_t dec;
  logic [31:0]            pc_o;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .fetch_req_i        (fetch_req),
    .wb_to_fetch_req_i  (wb_req),
    .imem               (imem),
    .fetch_to_decoder_o (dec),
    .pc_o               (pc_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: next fetch address, read in flight, stale read, decoded word.
  logic [31:0] m_pc, m_word, m_wpc;
  bit          m_busy, m_stale, m_have;
  bit          stray_ok;

  function automatic void model_reset();
    m_pc    = RST_PC;
    m_busy  = 1'b0;
    m_stale = 1'b0;
    m_have  = 1'b0;
    m_word  = 32'h0;
    m_wpc   = RST_PC;
  endfunction

  function automatic bit exp_req();
    return rst_n && !m_busy && !m_have && (fetch_req.state != fetch_nope);
  endfunction

  function automatic void model_step();
    bit hs;
    hs = exp_req() && imem.req_ready;
    if (wb_req.take_branch) begin
      m_have = 1'b0;
      if (m_busy) begin
        if (imem.rsp_valid) begin
          m_busy  = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end else if (hs) begin
        m_busy  = 1'b1;
        m_stale = 1'b1;
      end
      m_pc = wb_req.branch_value & ~32'h3;
    end else if (m_have) begin
      if (fetch_req.state == fetch_next) begin
        m_pc   = m_pc + 32'd4;
        m_have = 1'b0;
      end else if (fetch_req.state == fetch_nope) begin
        m_have = 1'b0;
      end
    end else if (m_busy) begin
      if (imem.rsp_valid) begin
        m_busy = 1'b0;
        if (!m_stale) begin
          m_have = 1'b1;
          m_word = imem.rsp_data;
          m_wpc  = m_pc;
        end
        m_stale = 1'b0;
      end
    end else if (hs) begin
      m_busy = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("req_valid", 32'(imem.req_valid_c), 32'(exp_req()));
    if (exp_req()) chk("req_addr", imem.req_addr, m_pc);
    chk("dec_valid", 32'(dec.valid), 32'(m_have));
    if (m_have) begin
      chk("dec_word", dec.raw_instruction, m_word);
      chk("pc_o", pc_o, m_wpc);
    end
    assert (!(imem.rsp_valid && !m_busy && !stray_ok))
    else $error("FAIL rsp_outside_wait: response driven with no read outstanding at %0t", $time);
  endtask

  // Called at the falling edge: drive inputs, let them settle.
  task automatic put(input fetch_state_e st, input bit rdy, input bit rsp_en,
                     input bit br = 1'b0, input logic [31:0] tgt = 32'h0);
    fetch_req.state         = st;
    imem.req_ready          = rdy;
    imem.rsp_valid          = rsp_en && m_busy;
    imem.rsp_data           = $urandom;
    wb_req.take_branch      = br;
    wb_req.branch_value     = tgt;
    #1;
  endtask

  task automatic tick();
    check_outputs();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic drive(input fetch_state_e st, input bit rdy, input bit rsp_en,
                       input bit br = 1'b0, input logic [31:0] tgt = 32'h0);
    put(st, rdy, rsp_en, br, tgt);
    tick();
  endtask

  task automatic to_hold();
    for (int i = 0; i < 8 && !m_have; i++) drive(fetch_next, 1'b1, 1'b1);
    tests++;
    assert (m_have)
    else begin
      fails++;
      $error("FAIL to_hold: no word delivered within 8 cycles");
    end
  endtask

  task automatic go_to(input logic [31:0] tgt);
    to_hold();
    drive(fetch_nope, 1'b1, 1'b1, 1'b1, tgt);
    to_hold();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] p;
    fetch_req.state     = fetch_next;
    wb_req              = '0;
    imem.req_ready      = 1'b1;
    imem.rsp_valid      = 1'b0;
    imem.rsp_data       = 32'h0;
    stray_ok            = 1'b0;
    model_reset();

    // Reset values
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem.req_valid_c), 32'h0);
    chk("rst_dec_valid", 32'(dec.valid), 32'h0);
    chk("rst_dec_word", dec.raw_instruction, 32'h0);
    chk("rst_pc_o", pc_o, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait streaming with fetch_next held
    for (int i = 0; i < 9; i++) begin
      put(fetch_next, 1'b1, 1'b1);
      if (i == 0) chk("stream_addr0", imem.req_addr, 32'h100);
      if (i == 2) begin
        chk("stream_valid0", 32'(dec.valid), 32'h1);
        chk("stream_pc0", pc_o, 32'h100);
      end
      if (i == 3) chk("stream_addr1", imem.req_addr, 32'h104);
      if (i == 6) chk("stream_addr2", imem.req_addr, 32'h108);
      tick();
    end

    // fetch_keep holds the word and issues nothing
    to_hold();
    p = m_wpc;
    repeat (5) drive(fetch_keep, 1'b1, 1'b1);
    drive(fetch_next, 1'b1, 1'b1);
    put(fetch_next, 1'b1, 1'b1);
    chk("keep_then_next_addr", imem.req_addr, p + 32'd4);
    tick();

    // fetch_nope replays the same PC
    go_to(32'h200);
    repeat (3) begin
      put(fetch_nope, 1'b1, 1'b1);
      chk("nope_no_req", 32'(imem.req_valid_c), 32'h0);
      tick();
    end
    put(fetch_next, 1'b1, 1'b1);
    chk("nope_replay_addr", imem.req_addr, 32'h200);
    tick();

    // Redirect while waiting: late response is dropped
    drive(fetch_next, 1'b1, 1'b0, 1'b1, 32'h403);
    drive(fetch_next, 1'b1, 1'b0);
    drive(fetch_next, 1'b1, 1'b0);
    put(fetch_next, 1'b1, 1'b1);
    chk("kill_resp_dropped", 32'(dec.valid), 32'h0);
    tick();
    put(fetch_next, 1'b1, 1'b1);
    chk("kill_next_addr", imem.req_addr, 32'h400);
    chk("kill_dec_invalid", 32'(dec.valid), 32'h0);
    tick();

    // Redirect beats fetch_next in HOLD
    go_to(32'h10);
    drive(fetch_next, 1'b1, 1'b1, 1'b1, 32'h80);
    put(fetch_next, 1'b1, 1'b1);
    chk("branch_wins_addr", imem.req_addr, 32'h80);
    tick();

    // PC wraps past the top of the address space
    go_to(32'hFFFF_FFFC);
    drive(fetch_next, 1'b1, 1'b1);
    put(fetch_next, 1'b1, 1'b1);
    chk("wrap_addr", imem.req_addr, 32'h0);
    tick();

    // Stalled request redirected before acceptance
    to_hold();
    drive(fetch_next, 1'b0, 1'b1);
    drive(fetch_next, 1'b0, 1'b1);
    drive(fetch_next, 1'b0, 1'b1, 1'b1, 32'h500);
    put(fetch_next, 1'b0, 1'b1);
    chk("stall_redir_addr", imem.req_addr, 32'h500);
    chk("stall_redir_valid", 32'(imem.req_valid_c), 32'h1);
    tick();
    drive(fetch_next, 1'b0, 1'b1);
    put(fetch_next, 1'b1, 1'b1);
    chk("stall_hs_addr", imem.req_addr, 32'h500);
    tick();
    to_hold();
    chk("stall_pc_o", pc_o, 32'h500);

    // Reset mid-transaction, then a stray late response
    drive(fetch_next, 1'b1, 1'b0);
    drive(fetch_next, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_req_valid", 32'(imem.req_valid_c), 32'h0);
    chk("midrst_dec_valid", 32'(dec.valid), 32'h0);
    chk("midrst_pc_o", pc_o, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;
    stray_ok = 1'b1;
    put(fetch_keep, 1'b0, 1'b0);
    imem.rsp_valid = 1'b1;
    #1;
    tick();
    stray_ok = 1'b0;
    put(fetch_next, 1'b1, 1'b1);
    chk("post_rst_addr", imem.req_addr, RST_PC);
    tick();
    to_hold();
    chk("post_rst_pc_o", pc_o, RST_PC);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(fetch_state_e'($urandom_range(2)), 1'($urandom_range(1)),
            ($urandom_range(3) != 0), ($urandom_range(9) == 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
